// File: rtl/vscale_dmem_arbiter_pkg.sv
// Shared constants for the multi-core data-memory arbiter (stands in for vscale_arb_constants.vh).
// Memory widths match the single-core vscale build.
package vscale_dmem_arbiter_pkg;

    localparam int XPR_LEN            = 32;
    localparam int MEM_TYPE_WIDTH     = 3;
    localparam int ARB_CORE_IDX_WIDTH = 2;
    localparam int ARB_MAX_CORES      = 4;

    // Successor of a core index, wrapping at the number of populated cores.
    function automatic int next_core(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/vscale_rr_picker.sv
// Rotating priority picker: first asserted request at or after `start`, wrapping.
// Produces a one-hot grant, its index, and an any-request flag.
module vscale_rr_picker #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_IDX_WIDTH = 2
) (
    input  logic [NUM_CORES-1:0]      req,
    input  logic [CORE_IDX_WIDTH-1:0] start,
    output logic [NUM_CORES-1:0]      grant,
    output logic [CORE_IDX_WIDTH-1:0] idx,
    output logic                      any
);

    int                        c;
    logic [CORE_IDX_WIDTH-1:0] ci;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        ci    = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            c  = (int'(start) + k) % NUM_CORES;
            ci = CORE_IDX_WIDTH'(c);
            if (!any && req[ci]) begin
                any       = 1'b1;
                grant[ci] = 1'b1;
                idx       = ci;
            end
        end
    end

endmodule

// File: rtl/vscale_dmem_arbiter.sv
// Shares one data-memory port among NUM_CORES vscale pipelines; grants in DX, routes WB data.
// Define VSCALE_DMEM_ARB_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module vscale_dmem_arbiter
    import vscale_dmem_arbiter_pkg::*;
#(
    parameter int NUM_CORES      = 4,
    parameter int CORE_IDX_WIDTH = ARB_CORE_IDX_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CORES-1:0]                core_dmem_en,
    input  logic [NUM_CORES-1:0]                core_dmem_wen,
    input  logic [NUM_CORES*MEM_TYPE_WIDTH-1:0] core_dmem_size,
    input  logic [NUM_CORES*XPR_LEN-1:0]        core_dmem_addr,
    input  logic [NUM_CORES*XPR_LEN-1:0]        core_dmem_wdata,
    output logic [NUM_CORES-1:0]                core_dmem_wait,
    output logic [XPR_LEN-1:0]                  core_dmem_rdata,
    output logic [NUM_CORES-1:0]                core_dmem_badmem_e,
    output logic                                mem_en,
    output logic                                mem_wen,
    output logic [MEM_TYPE_WIDTH-1:0]           mem_size,
    output logic [XPR_LEN-1:0]                  mem_addr,
    output logic [XPR_LEN-1:0]                  mem_wdata,
    input  logic [XPR_LEN-1:0]                  mem_rdata,
    input  logic                                mem_wait,
    input  logic                                mem_badmem_e,
    output logic [CORE_IDX_WIDTH-1:0]           grant_idx
);

    logic [MEM_TYPE_WIDTH-1:0] size_a  [NUM_CORES];
    logic [XPR_LEN-1:0]        addr_a  [NUM_CORES];
    logic [XPR_LEN-1:0]        wdata_a [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_unpack
        assign size_a[i]  = core_dmem_size[i*MEM_TYPE_WIDTH +: MEM_TYPE_WIDTH];
        assign addr_a[i]  = core_dmem_addr[i*XPR_LEN +: XPR_LEN];
        assign wdata_a[i] = core_dmem_wdata[i*XPR_LEN +: XPR_LEN];
    end

    logic [NUM_CORES-1:0]      grant_oh;
    logic [CORE_IDX_WIDTH-1:0] win;
    logic [CORE_IDX_WIDTH-1:0] start;
    logic                      any_req;

    logic                      dp_valid_q;
    logic                      dp_wen_q;
    logic [CORE_IDX_WIDTH-1:0] dp_owner_q;

`ifdef VSCALE_DMEM_ARB_RR_EN
    logic [CORE_IDX_WIDTH-1:0] rr_ptr_q;
    logic                      accept;

    assign accept = any_req & ~mem_wait;

    always_ff @(posedge clk) begin
        if (!reset)
            rr_ptr_q <= '0;
        else if (accept)
            rr_ptr_q <= CORE_IDX_WIDTH'(next_core(int'(win), NUM_CORES));
    end

    assign start = rr_ptr_q;
`else
    assign start = '0;
`endif

    vscale_rr_picker #(
        .NUM_CORES     (NUM_CORES),
        .CORE_IDX_WIDTH(CORE_IDX_WIDTH)
    ) picker (
        .req  (core_dmem_en),
        .start(start),
        .grant(grant_oh),
        .idx  (win),
        .any  (any_req)
    );

    // Address phase: purely combinational from the requests.
    always_comb begin
        mem_en         = 1'b0;
        mem_wen        = 1'b0;
        mem_size       = '0;
        mem_addr       = '0;
        grant_idx      = '0;
        core_dmem_wait = '1;
        if (reset) begin
            grant_idx      = win;
            core_dmem_wait = {NUM_CORES{mem_wait}} | (core_dmem_en & ~grant_oh);
            if (any_req) begin
                mem_en   = 1'b1;
                mem_wen  = core_dmem_wen[win];
                mem_size = size_a[win];
                mem_addr = addr_a[win];
            end
        end
    end

    // Data-phase ownership advances only when memory accepts the current phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dp_valid_q <= 1'b0;
            dp_owner_q <= '0;
            dp_wen_q   <= 1'b0;
        end else if (!mem_wait) begin
            dp_valid_q <= any_req;
            dp_owner_q <= win;
            dp_wen_q   <= mem_wen;
        end
    end

    always_comb begin
        mem_wdata          = '0;
        core_dmem_badmem_e = '0;
        if (dp_valid_q && dp_wen_q)
            mem_wdata = wdata_a[dp_owner_q];
        if (reset && dp_valid_q)
            core_dmem_badmem_e[dp_owner_q] = mem_badmem_e;
    end

    assign core_dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_vscale_dmem_arbiter.sv
// Randomized + directed bench for vscale_dmem_arbiter against a transaction-level model.
// Honours VSCALE_DMEM_ARB_RR_EN the same way the design does.
module tb_vscale_dmem_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   core_dmem_en, core_dmem_wen;
    logic [11:0]  core_dmem_size;
    logic [127:0] core_dmem_addr, core_dmem_wdata;
    logic [3:0]   core_dmem_wait, core_dmem_badmem_e;
    logic [31:0]  core_dmem_rdata;
    logic         mem_en, mem_wen;
    logic [2:0]   mem_size;
    logic [31:0]  mem_addr, mem_wdata, mem_rdata;
    logic         mem_wait, mem_badmem_e;
    logic [1:0]   grant_idx;

    always #5 clk = ~clk;

    vscale_dmem_arbiter #(.NUM_CORES(4), .CORE_IDX_WIDTH(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .core_dmem_en      (core_dmem_en),
        .core_dmem_wen     (core_dmem_wen),
        .core_dmem_size    (core_dmem_size),
        .core_dmem_addr    (core_dmem_addr),
        .core_dmem_wdata   (core_dmem_wdata),
        .core_dmem_wait    (core_dmem_wait),
        .core_dmem_rdata   (core_dmem_rdata),
        .core_dmem_badmem_e(core_dmem_badmem_e),
        .mem_en            (mem_en),
        .mem_wen           (mem_wen),
        .mem_size          (mem_size),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_wait          (mem_wait),
        .mem_badmem_e      (mem_badmem_e),
        .grant_idx         (grant_idx)
    );

    // Per-core request payloads.
    logic [2:0]  s_sz [N];
    logic [31:0] s_ad [N];
    logic [31:0] s_wd [N];

    // Model state: next grant origin and the pending data-phase transaction.
    int   m_ptr = 0;
    bit   m_dv  = 0;
    int   m_do  = 0;
    bit   m_dw  = 0;
    int   m_lastw;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester with the smallest rotational distance from the search origin; -1 if none.
    function automatic int pick(input logic [3:0] e, input int ptr);
        int best = -1;
        int bd   = N;
        for (int i = 0; i < N; i++) begin
            if (((e >> i) & 4'd1) != 4'd0) begin
                int d = (i - ptr + N) % N;
                if (d < bd) begin
                    bd   = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic step(input logic rst, input logic [3:0] e, input logic [3:0] w,
                        input logic mw, input logic bad, input logic [31:0] rd);
        int         win, wi;
        bit         any;
        logic       e_wen;
        logic [3:0] e_wait, e_bad;
        logic [31:0] e_wdata;
        @(negedge clk);
        reset           = rst;
        core_dmem_en    = e;
        core_dmem_wen   = w;
        core_dmem_size  = {s_sz[3], s_sz[2], s_sz[1], s_sz[0]};
        core_dmem_addr  = {s_ad[3], s_ad[2], s_ad[1], s_ad[0]};
        core_dmem_wdata = {s_wd[3], s_wd[2], s_wd[1], s_wd[0]};
        mem_wait        = mw;
        mem_badmem_e    = bad;
        mem_rdata       = rd;
        #1;
        win = pick(e, m_ptr);
        any = (win >= 0);
        wi  = any ? win : 0;
        m_lastw = win;
        e_wen = (rst && any) ? w[wi[1:0]] : 1'b0;
        e_wait = 4'hF;
        if (rst)
            for (int i = 0; i < N; i++)
                e_wait[i[1:0]] = mw | (e[i[1:0]] && i != win);
        e_wdata = (m_dv && m_dw) ? s_wd[m_do[1:0]] : 32'd0;
        e_bad = (rst && m_dv && bad) ? (4'd1 << m_do) : 4'd0;

        chk("mem_en",   {31'd0, mem_en},  {31'd0, rst && any});
        chk("mem_wen",  {31'd0, mem_wen}, {31'd0, e_wen});
        chk("mem_size", {29'd0, mem_size}, (rst && any) ? {29'd0, s_sz[wi[1:0]]} : 32'd0);
        chk("mem_addr", mem_addr, (rst && any) ? s_ad[wi[1:0]] : 32'd0);
        if (!rst || any)
            chk("grant_idx", {30'd0, grant_idx}, rst ? 32'(wi) : 32'd0);
        chk("core_wait",  {28'd0, core_dmem_wait}, {28'd0, e_wait});
        chk("mem_wdata",  mem_wdata, e_wdata);
        chk("badmem",     {28'd0, core_dmem_badmem_e}, {28'd0, e_bad});
        chk("rdata",      core_dmem_rdata, rd);

        if (!rst) begin
            m_dv = 0; m_do = 0; m_dw = 0; m_ptr = 0;
        end else if (!mw) begin
            m_dv = any; m_do = wi; m_dw = e_wen;
`ifdef VSCALE_DMEM_ARB_RR_EN
            if (any) m_ptr = (win + 1) % N;
`endif
        end
    endtask

    logic [3:0] pending;

    initial begin
        for (int i = 0; i < N; i++) begin
            s_sz[i] = 3'd2; s_ad[i] = 32'd0; s_wd[i] = 32'd0;
        end
        reset = 1'b0; core_dmem_en = '0; core_dmem_wen = '0;
        core_dmem_size = '0; core_dmem_addr = '0; core_dmem_wdata = '0;
        mem_rdata = '0; mem_wait = 1'b0; mem_badmem_e = 1'b0;

        repeat (3) step(0, 4'b1111, 4'b1111, 0, 1, 32'h1);
        chk("rst_wait", {28'd0, core_dmem_wait}, 32'hF);

        // Single requester: core 2 load at 0x40.
        s_ad[2] = 32'h40;
        step(1, 4'b0100, 4'b0000, 0, 0, 32'h0);
        chk("single_addr",  mem_addr, 32'h40);
        chk("single_grant", {30'd0, grant_idx}, 32'd2);
        step(1, 4'b0000, 4'b0000, 0, 0, 32'hDEADBEEF);
        chk("single_rdata", core_dmem_rdata, 32'hDEADBEEF);

        // All four storing; each drops its request once granted.
        for (int i = 0; i < N; i++) begin
            s_ad[i] = 32'h100 + 32'(4 * i);
            s_wd[i] = 32'hA0 + 32'(i);
        end
        pending = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step(1, pending, pending, 0, 0, $urandom);
            if (k > 0) chk("all4_wdata", mem_wdata, 32'hA0 + 32'(k - 1));
            if (k < 4) begin
                chk("all4_grant", {30'd0, grant_idx}, 32'(k));
                pending[m_lastw[1:0]] = 1'b0;
            end
        end

        // Cores 1 and 3 contending.
        repeat (3) begin
            step(1, 4'b1010, 4'b0000, 0, 0, $urandom);
`ifndef VSCALE_DMEM_ARB_RR_EN
            chk("fixed_grant", {30'd0, grant_idx}, 32'd1);
            chk("fixed_wait3", {31'd0, core_dmem_wait[3]}, 32'd1);
`endif
        end
        step(1, 4'b0000, 4'b0000, 0, 0, 32'h0);

        // Memory stall during core 0 store data phase.
        s_wd[0] = 32'hC0FFEE00;
        step(1, 4'b0001, 4'b0001, 0, 0, 32'h0);
        repeat (2) begin
            step(1, 4'b0110, 4'b0000, 1, 0, 32'h0);
            chk("stall_wdata", mem_wdata, 32'hC0FFEE00);
            chk("stall_wait",  {28'd0, core_dmem_wait}, 32'hF);
        end
        step(1, 4'b0110, 4'b0000, 0, 0, 32'h0);
        step(1, 4'b0000, 4'b0000, 0, 0, 32'h0);

        // Bus error during core 1 data phase.
        step(1, 4'b0010, 4'b0000, 0, 0, 32'h0);
        step(1, 4'b0000, 4'b0000, 0, 1, 32'h0);
        chk("badmem_core1", {28'd0, core_dmem_badmem_e}, 32'h2);

        // Reset during an outstanding core 3 store.
        step(1, 4'b1000, 4'b1000, 0, 0, 32'h0);
        step(0, 4'b1111, 4'b0000, 0, 1, 32'h0);
        step(0, 4'b1111, 4'b0000, 0, 1, 32'h0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        step(1, 4'b0101, 4'b0000, 0, 0, 32'h0);
        chk("post_rst_grant", {30'd0, grant_idx}, 32'd0);
        chk("post_rst_wdata", mem_wdata, 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                s_sz[i] = 3'($urandom_range(0, 7));
                s_ad[i] = $urandom;
                s_wd[i] = $urandom;
            end
            step(($urandom_range(0, 39) != 0), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_dmem_arbiter.md
# vscale_dmem_arbiter

Shares the single data-memory port among `NUM_CORES` vscale pipelines in the multi-core build. The grant is decided in the address phase (the core's DX stage). The arbiter tracks the owner of the following data phase (the core's WB stage), so each core's delayed store data and its load response are routed correctly. Cores that lose arbitration see `dmem_wait` and hold their request until granted.

## Interface
- `NUM_CORES`, 4: number of requesting pipelines, 2..4.
- `CORE_IDX_WIDTH`, 2: width of core index; `NUM_CORES` ≤ 2^`CORE_IDX_WIDTH`.
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  synchronous, active-low reset (sampled on posedge `clk`; 0 = reset).
- `core_dmem_en`  in  NUM_CORES  per-core address-phase request.
- `core_dmem_wen`  in  NUM_CORES  per-core write enable.
- `core_dmem_size`  in  NUM_CORES*MEM_TYPE_WIDTH  packed access size.
- `core_dmem_addr`  in  NUM_CORES*XPR_LEN  packed address.
- `core_dmem_wdata`  in  NUM_CORES*XPR_LEN  packed data-phase store data (`dmem_wdata_delayed`).
- `core_dmem_wait`  out  NUM_CORES  per-core stall.
- `core_dmem_rdata`  out  XPR_LEN  load data, broadcast to all cores.
- `core_dmem_badmem_e`  out  NUM_CORES  bus error, asserted only to the data-phase owner.
- `mem_en`, `mem_wen`  out  1  memory address phase.
- `mem_size`  out  MEM_TYPE_WIDTH.
- `mem_addr`  out  XPR_LEN.
- `mem_wdata`  out  XPR_LEN  owner's store data in the data phase.
- `mem_rdata`  in  XPR_LEN.
- `mem_wait`  in  1  memory stall, applies to the current data phase.
- `mem_badmem_e`  in  1.
- `grant_idx`  out  CORE_IDX_WIDTH  debug: address-phase winner, valid when `mem_en`=1.

## Operation
- **Address phase (combinational):**
  - Winner W is chosen among asserted `core_dmem_en` bits.
  - `mem_en`/`wen`/`size`/`addr` come from W.
  - If nothing is requested, `mem_en`=0 and the other memory outputs are 0.
- **Data-phase registers:** `dp_valid_q`, `dp_owner_q`, `dp_wen_q`.
  - They load `{mem_en, W, mem_wen}` on each posedge where `mem_wait`=0 and `reset`=1.
  - They hold while `mem_wait`=1.
- **Data phase outputs:**
  - `mem_wdata` = `core_dmem_wdata[dp_owner_q]` when `dp_valid_q & dp_wen_q`, else 0.
  - `core_dmem_badmem_e[dp_owner_q]` = `mem_badmem_e & dp_valid_q`.
  - `core_dmem_rdata` = `mem_rdata` unconditionally.
- **Per-core stall:** `core_dmem_wait[i]` = `mem_wait` | (`core_dmem_en[i]` & (W≠i)).
  - A granted core proceeds.
  - A losing core stalls with its request held stable; the arbiter requires stability but does not check it.
- **Arbitration state:** `rr_ptr_q` (CORE_IDX_WIDTH).
  - Priority search starts at `rr_ptr_q`.
  - On an accepted grant (`mem_en` & ~`mem_wait`), `rr_ptr_q` ← W+1, wrapping NUM_CORES-1 → 0.
- **Memory stall:** while `mem_wait`=1, every core sees wait=1. No grant is accepted, and `rr_ptr_q` and the data-phase registers hold.
- **Reset asserted (`reset`=0):**
  - `rr_ptr_q`=0, `dp_valid_q`=0, `dp_owner_q`=0, `dp_wen_q`=0.
  - Outputs forced: `mem_en`=0, `mem_wen`=0, `core_dmem_wait`=all 1s, `core_dmem_badmem_e`=0, `grant_idx`=0.
  - Reset mid-transaction drops the outstanding data phase without completing it.

## Timing
- Address phase: zero-cycle latency, combinational from requests to `mem_*`.
- Data phase: exactly one accepted cycle after the address phase; extended by each `mem_wait` cycle.
- Throughput: one accepted access per cycle aggregate when memory does not stall.
- Back-to-back: address phase of access N+1 overlaps data phase of access N, possibly from different cores.
- Fairness: with all cores requesting continuously, each core is granted once every NUM_CORES accepted cycles.
- No combinational path from `mem_rdata` to any `mem_*` output.

## Configuration
- `VSCALE_DMEM_ARB_RR_EN` defined: round-robin as above.
- Undefined: fixed priority, lowest index wins. `rr_ptr_q` is not instantiated; the search always starts at 0.

## Structure
- Shared package/header `vscale_arb_constants.vh`: `CORE_IDX_WIDTH`, max-cores constant, and arbiter width macros.
- Reuse `XPR_LEN` and `MEM_TYPE_WIDTH` from the existing header.
- One sub-module, `vscale_rr_picker`: request vector + start pointer → one-hot grant + index. The fixed-priority build ties the pointer to 0.

## Test plan
- **Single requester:** core 2 load at addr 0x40, `mem_rdata`=0xDEADBEEF.
  - Expect `mem_addr`=0x40, `grant_idx`=2, `core_dmem_wait`=0000.
  - Next cycle: `core_dmem_rdata`=0xDEADBEEF, `dp_owner_q`=2.
- **All four storing simultaneously** (RR build), addrs 0x100+4i, data 0xA0+i.
  - Grants 0,1,2,3 on consecutive cycles.
  - `mem_wdata` follows one cycle behind: 0xA0..0xA3.
  - Losers see wait=1 until granted.
- **Fixed-priority build, cores 1 and 3 requesting** for 3 cycles: core 1 granted every cycle; core 3 wait=1 throughout.
- **`mem_wait`=1 for 2 cycles during core 0 store data phase:**
  - `mem_wdata` held at core 0 data.
  - All waits=1.
  - `rr_ptr_q` unchanged.
  - Grant resumes on release.
- **`mem_badmem_e`=1 during core 1 data phase:** only `core_dmem_badmem_e[1]`=1.
- **`reset`=0 asserted during an outstanding core 3 data phase:**
  - Next cycle `dp_valid_q`=0, `mem_en`=0, waits all 1s.
  - After release, the first grant goes to the lowest requesting index (`rr_ptr_q`=0).
